// File: rtl/strip_occupancy_table_pkg.sv
// ---------------------------------------------------------------------------------------------
// strip_occupancy_table_pkg
// Shared constants, types and helpers for the strip occupancy table.
//   NUM_STRIPS   : strips held in the table (ids 0..NUM_STRIPS-1)
//   STRIP_WIDTH  : usable width per strip; a stored width of this value means "strip full"
//   ID_W / WID_W : strip-id and occupied-width bit widths
//   CNT_W        : strike counter width (only meaningful with STRIKE_COUNT_EN)
// ---------------------------------------------------------------------------------------------
package strip_occupancy_table_pkg;

   localparam int unsigned NUM_STRIPS  = 13;
   localparam int unsigned STRIP_WIDTH = 128;
   localparam int unsigned ID_W        = 4;
   localparam int unsigned WID_W       = 8;
   localparam int unsigned CNT_W       = 8;

   // Whole table as one packed vector so it can be handed to the lookup helper.
   typedef logic [NUM_STRIPS-1:0][WID_W-1:0] width_tbl_t;

   // One placement record, emitted one cycle after each commit.
   typedef struct packed {
      logic [ID_W-1:0]  strip_id;
      logic [WID_W-1:0] x;
      logic             strike;
   } place_rec_t;

   // Width seen by a reader: same-cycle write wins, illegal ids read as full so the
   // min-select stage never picks them.
   function automatic logic [WID_W-1:0] lookup_width(input width_tbl_t       tbl,
                                                     input logic [ID_W-1:0]  id,
                                                     input logic             byp_en,
                                                     input logic [ID_W-1:0]  byp_id,
                                                     input logic [WID_W-1:0] byp_w);
      logic [WID_W-1:0] w;
      w = WID_W'(STRIP_WIDTH);
      if (byp_en && (byp_id == id)) begin
         w = byp_w;
      end else begin
         for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            if (id == ID_W'(i)) begin
               w = tbl[i];
            end
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/strip_occupancy_table_if.sv
// ---------------------------------------------------------------------------------------------
// strip_occupancy_table_if
// Read, commit and placement-record signals between the pipeline and the occupancy table.
//   rd_id_1/2/3, occupied_width_1/2/3 : three combinational candidate lookups
//   upd_*                              : commit from the strike stage
//   place_*                            : registered placement record
// Modports: master = pipeline side (drives reads/commits), slave = the table.
// ---------------------------------------------------------------------------------------------
interface strip_occupancy_table_if;
   import strip_occupancy_table_pkg::*;

   logic [ID_W-1:0]  rd_id_1;
   logic [ID_W-1:0]  rd_id_2;
   logic [ID_W-1:0]  rd_id_3;
   logic [WID_W-1:0] occupied_width_1;
   logic [WID_W-1:0] occupied_width_2;
   logic [WID_W-1:0] occupied_width_3;

   logic             upd_valid;
   logic [ID_W-1:0]  upd_strip_id;
   logic [WID_W-1:0] upd_old_width;
   logic             upd_strike;
   logic [WID_W-1:0] upd_new_width;

   logic             place_valid;
   logic [ID_W-1:0]  place_strip_id;
   logic [WID_W-1:0] place_x;
   logic             place_strike;

   modport master (
      output rd_id_1, rd_id_2, rd_id_3,
      input  occupied_width_1, occupied_width_2, occupied_width_3,
      output upd_valid, upd_strip_id, upd_old_width, upd_strike, upd_new_width,
      input  place_valid, place_strip_id, place_x, place_strike
   );

   modport slave (
      input  rd_id_1, rd_id_2, rd_id_3,
      output occupied_width_1, occupied_width_2, occupied_width_3,
      input  upd_valid, upd_strip_id, upd_old_width, upd_strike, upd_new_width,
      output place_valid, place_strip_id, place_x, place_strike
   );

endinterface

// File: rtl/strip_occupancy_table_strike_counter.sv
// ---------------------------------------------------------------------------------------------
// strip_occupancy_table_strike_counter
// Saturating up-counter of strike commits.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset, clears the count
//   i_inc    : count one strike this cycle
//   o_count  : current count, sticks at 2**CNT_W-1
// ---------------------------------------------------------------------------------------------
module strip_occupancy_table_strike_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_d;

   always_comb begin
      w_count_d = r_count;
      if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         w_count_d = r_count + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_d;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/strip_occupancy_table.sv
// ---------------------------------------------------------------------------------------------
// strip_occupancy_table
// Write-back end of the placement pipeline: holds the occupied width of every strip, serves
// three zero-latency candidate lookups (with write-through of a same-cycle commit), commits
// the strike stage's result and emits one registered placement record per commit.
//   i_clk          : clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   bus (slave)    : lookups, commit strobe/fields, placement record
//   o_upd_err      : sticky, set by a commit with an illegal id or a new width > STRIP_WIDTH
//   o_strip_full   : bit i set when strip i is at STRIP_WIDTH (from the registered table)
//   o_strike_count : saturating strike count, present only when STRIKE_COUNT_EN is defined
// Build option: define STRIKE_COUNT_EN to include the strike counter and its port.
// ---------------------------------------------------------------------------------------------
module strip_occupancy_table
   import strip_occupancy_table_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   strip_occupancy_table_if.slave bus,
   output logic                   o_upd_err,
`ifdef STRIKE_COUNT_EN
   output logic [CNT_W-1:0]       o_strike_count,
`endif
   output logic [NUM_STRIPS-1:0]  o_strip_full
);

   width_tbl_t r_width;
   logic       r_upd_err;
   logic       r_place_valid;
   place_rec_t r_place_rec;

   logic       w_id_legal;
   logic       w_new_legal;
   logic       w_wr_en;
   logic       w_err_set;
   place_rec_t w_rec;

   // Commit decode. A strike carries no meaningful new width, so only the id is
   // checked for legality on strike commits.
   always_comb begin
      w_id_legal  = (bus.upd_strip_id < ID_W'(NUM_STRIPS));
      w_new_legal = (bus.upd_new_width <= WID_W'(STRIP_WIDTH));
      w_wr_en     = bus.upd_valid && !bus.upd_strike && w_id_legal && w_new_legal;
      w_err_set   = bus.upd_valid && (!w_id_legal || (!bus.upd_strike && !w_new_legal));
   end

   // Candidate lookups; bypass only when the commit really writes the table.
   always_comb begin
      bus.occupied_width_1 = lookup_width(r_width, bus.rd_id_1, w_wr_en,
                                          bus.upd_strip_id, bus.upd_new_width);
      bus.occupied_width_2 = lookup_width(r_width, bus.rd_id_2, w_wr_en,
                                          bus.upd_strip_id, bus.upd_new_width);
      bus.occupied_width_3 = lookup_width(r_width, bus.rd_id_3, w_wr_en,
                                          bus.upd_strip_id, bus.upd_new_width);
   end

   // Width table.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_width <= '0;
      end else if (w_wr_en) begin
         for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            if (bus.upd_strip_id == ID_W'(i)) begin
               r_width[i] <= bus.upd_new_width;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_upd_err <= 1'b0;
      end else if (w_err_set) begin
         r_upd_err <= 1'b1;
      end
   end

   // Placement record: every commit (legal or not) produces one; fields hold between pulses.
   always_comb begin
      w_rec.strip_id = bus.upd_strip_id;
      w_rec.x        = bus.upd_old_width;
      w_rec.strike   = bus.upd_strike;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_place_valid <= 1'b0;
         r_place_rec   <= '0;
      end else begin
         r_place_valid <= bus.upd_valid;
         if (bus.upd_valid) begin
            r_place_rec <= w_rec;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
         o_strip_full[i] = (r_width[i] == WID_W'(STRIP_WIDTH));
      end
   end

   assign bus.place_valid    = r_place_valid;
   assign bus.place_strip_id = r_place_rec.strip_id;
   assign bus.place_x        = r_place_rec.x;
   assign bus.place_strike   = r_place_rec.strike;
   assign o_upd_err          = r_upd_err;

`ifdef STRIKE_COUNT_EN
   strip_occupancy_table_strike_counter #(
      .CNT_W (CNT_W)
   ) u_strike_counter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (bus.upd_valid && bus.upd_strike),
      .o_count (o_strike_count)
   );
`endif

endmodule
